// File: rtl/prefix_adder_pkg.sv
//------------------------------------------------------------------------------
// Module  : prefix_adder_pkg
// Brief   : Shared constants and elaboration helpers for the prefix adder.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package prefix_adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // ceil(log2(w)), w >= 2
    function automatic int levels(input int w);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < w) r = i + 1;
        end
        return r;
    endfunction

    // Prefix level after which pipeline register j (1..pipe-1) sits.
    function automatic int stage_after_level(input int j, input int pipe, input int lv);
        return ((j * lv) + pipe - 1) / pipe - 1;
    endfunction

    function automatic bit reg_after_level(input int k, input int pipe, input int lv);
        bit hit;
        hit = 1'b0;
        for (int j = 1; j < pipe; j++) begin
            if (stage_after_level(j, pipe, lv) == k) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

`default_nettype wire

// File: rtl/prefix_level.sv
//------------------------------------------------------------------------------
// Module  : prefix_level
// Brief   : One Kogge-Stone level: combines each position with position-SPAN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module prefix_level #(
    parameter int N    = 17,
    parameter int SPAN = 1
) (
    input  logic [N-1:0] i_g,
    input  logic [N-1:0] i_p,
    output logic [N-1:0] o_g,
    output logic [N-1:0] o_p
);

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_bit
            if (i < SPAN) begin : g_pass
                assign o_g[i] = i_g[i];
                assign o_p[i] = i_p[i];
            end else begin : g_comb
                assign o_g[i] = i_g[i] | (i_p[i] & i_g[i-SPAN]);
                assign o_p[i] = i_p[i] & i_p[i-SPAN];
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/pipelined_prefix_adder.sv
//------------------------------------------------------------------------------
// Module  : pipelined_prefix_adder
// Brief   : Pipelined Kogge-Stone add/sub with flags, tag and valid/ready.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipelined_prefix_adder
    import prefix_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int PIPE  = 2,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_op,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LEVELS = levels(WIDTH);
    localparam int N      = WIDTH + 1;

    logic w_adv;
    assign w_adv    = out_ready | ~out_valid;
    assign in_ready = w_adv & ~flush;

    // Values at each level boundary; element k feeds prefix level k.
    logic [N-1:0]     w_g   [LEVELS+1];
    logic [N-1:0]     w_p   [LEVELS+1];
    logic [WIDTH-1:0] w_x   [LEVELS+1];
    logic             w_v   [LEVELS+1];
    logic             w_am  [LEVELS+1];
    logic             w_bm  [LEVELS+1];
    logic [TAG_W-1:0] w_tag [LEVELS+1];

    logic [WIDTH-1:0] w_bp;
    logic             w_cin;
    assign w_bp  = (in_op == OP_SUB) ? ~in_b : in_b;
    assign w_cin = (in_op == OP_SUB) ? 1'b1 : in_cin;

    // Position 0 holds the carry-in as a pure generate (propagate forced low).
    assign w_g[0]   = {in_a & w_bp, w_cin};
    assign w_p[0]   = {in_a | w_bp, 1'b0};
    assign w_x[0]   = in_a ^ w_bp;
    assign w_v[0]   = in_valid & in_ready;
    assign w_am[0]  = in_a[WIDTH-1];
    assign w_bm[0]  = w_bp[WIDTH-1];
    assign w_tag[0] = in_tag;

    genvar k;
    generate
        for (k = 0; k < LEVELS; k++) begin : g_level
            logic [N-1:0] w_lg;
            logic [N-1:0] w_lp;

            prefix_level #(.N(N), .SPAN(1 << k)) u_level (
                .i_g(w_g[k]),
                .i_p(w_p[k]),
                .o_g(w_lg),
                .o_p(w_lp)
            );

            if (reg_after_level(k, PIPE, LEVELS)) begin : g_reg
                logic             r_v;
                logic             r_am;
                logic             r_bm;
                logic [N-1:0]     r_g;
                logic [N-1:0]     r_p;
                logic [WIDTH-1:0] r_x;
                logic [TAG_W-1:0] r_tag;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_v   <= 1'b0;
                        r_am  <= 1'b0;
                        r_bm  <= 1'b0;
                        r_g   <= '0;
                        r_p   <= '0;
                        r_x   <= '0;
                        r_tag <= '0;
                    end else begin
                        if (flush)      r_v <= 1'b0;
                        else if (w_adv) r_v <= w_v[k];
                        if (w_adv) begin
                            r_am  <= w_am[k];
                            r_bm  <= w_bm[k];
                            r_g   <= w_lg;
                            r_p   <= w_lp;
                            r_x   <= w_x[k];
                            r_tag <= w_tag[k];
                        end
                    end
                end

                assign w_v[k+1]   = r_v;
                assign w_am[k+1]  = r_am;
                assign w_bm[k+1]  = r_bm;
                assign w_g[k+1]   = r_g;
                assign w_p[k+1]   = r_p;
                assign w_x[k+1]   = r_x;
                assign w_tag[k+1] = r_tag;
            end else begin : g_wire
                assign w_v[k+1]   = w_v[k];
                assign w_am[k+1]  = w_am[k];
                assign w_bm[k+1]  = w_bm[k];
                assign w_g[k+1]   = w_lg;
                assign w_p[k+1]   = w_lp;
                assign w_x[k+1]   = w_x[k];
                assign w_tag[k+1] = w_tag[k];
            end
        end
    endgenerate

    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf;
    assign w_sum  = w_x[LEVELS] ^ w_g[LEVELS][WIDTH-1:0];
    // When 2^LEVELS == WIDTH the top group stops at position 1; fold in the carry-in.
    assign w_cout = w_g[LEVELS][WIDTH] | (w_p[LEVELS][WIDTH] & w_g[LEVELS][0]);
    assign w_ovf  = (w_am[LEVELS] == w_bm[LEVELS]) & (w_sum[WIDTH-1] != w_am[LEVELS]);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_sum;
    logic             r_out_cout;
    logic             r_out_ovf;
    logic             r_out_zero;
    logic [TAG_W-1:0] r_out_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_cout  <= 1'b0;
            r_out_ovf   <= 1'b0;
            r_out_zero  <= 1'b0;
            r_out_tag   <= '0;
        end else begin
            if (flush)      r_out_valid <= 1'b0;
            else if (w_adv) r_out_valid <= w_v[LEVELS];
            if (w_adv) begin
                r_out_sum  <= w_sum;
                r_out_cout <= w_cout;
                r_out_ovf  <= w_ovf;
                r_out_zero <= (w_sum == '0);
                r_out_tag  <= w_tag[LEVELS];
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_cout  = r_out_cout;
    assign out_ovf   = r_out_ovf;
    assign out_zero  = r_out_zero;
    assign out_tag   = r_out_tag;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_prefix_adder.sv
//------------------------------------------------------------------------------
// Module  : tb_pipelined_prefix_adder
// Brief   : Directed and randomised checks of the pipelined prefix adder.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipelined_prefix_adder;
    import prefix_adder_pkg::*;

    localparam int WIDTH = 16;
    localparam int PIPE  = 2;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_op;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;
    logic [TAG_W-1:0] out_tag;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipelined_prefix_adder #(.WIDTH(WIDTH), .PIPE(PIPE), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_op(in_op), .in_tag(in_tag),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
        .out_zero(out_zero), .out_tag(out_tag)
    );

    // Reference: {tag, zero, ovf, cout, sum}
    function automatic logic [22:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic op, input logic [3:0] tag);
        logic [15:0] bp;
        logic [16:0] full;
        logic        ov;
        bp   = op ? ~b : b;
        full = {1'b0, a} + {1'b0, bp} + {16'd0, (op ? 1'b1 : cin)};
        ov   = (a[15] == bp[15]) && (full[15] != a[15]);
        return {tag, (full[15:0] == 16'd0), ov, full[16], full[15:0]};
    endfunction

    // Issue one operation into an idle pipe and collect its result.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic op, input logic [3:0] tag,
                         output logic [22:0] res, output int lat);
        @(negedge clk);
        out_ready = 1'b1;
        in_a = a; in_b = b; in_cin = cin; in_op = op; in_tag = tag;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = -1;
        res = {out_tag, out_zero, out_ovf, out_cout, out_sum};
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_op = OP_ADD; in_tag = '0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid: got %b expected 0", out_valid);
        end
        n_cmp++;
        if ({out_tag, out_zero, out_ovf, out_cout, out_sum} !== 23'd0) begin
            n_err++;
            $display("FAIL reset_data: got %h expected 0", {out_tag, out_zero, out_ovf, out_cout, out_sum});
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_add();
        logic [15:0] va [4] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h00FF};
        logic [15:0] vb [4] = '{16'h4321, 16'h0000, 16'h0001, 16'h0001};
        logic        vc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        // {tag, zero, ovf, cout, sum}
        logic [22:0] ex [4] = '{{4'd1, 3'b000, 16'h5555}, {4'd2, 3'b101, 16'h0000},
                                {4'd3, 3'b010, 16'h8000}, {4'd4, 3'b000, 16'h0101}};
        logic [22:0] res;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], vc[i], OP_ADD, 4'(i + 1), res, lat);
            n_cmp++;
            if (lat != PIPE) begin
                n_err++; $display("FAIL add%0d_latency: got %0d expected %0d", i, lat, PIPE);
            end
            n_cmp++;
            if (res !== ex[i]) begin
                n_err++; $display("FAIL add%0d_result: got %h expected %h", i, res, ex[i]);
            end
        end
    endtask

    task automatic test_sub();
        logic [15:0] va [4] = '{16'h8000, 16'h0003, 16'h0005, 16'h0010};
        logic [15:0] vb [4] = '{16'h0001, 16'h0005, 16'h0005, 16'h0001};
        logic        vc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [22:0] ex [4] = '{{4'd9, 3'b011, 16'h7FFF}, {4'd10, 3'b000, 16'hFFFE},
                                {4'd11, 3'b101, 16'h0000}, {4'd12, 3'b001, 16'h000F}};
        logic [22:0] res;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], vc[i], OP_SUB, 4'(i + 9), res, lat);
            n_cmp++;
            if (res !== ex[i]) begin
                n_err++; $display("FAIL sub%0d_result: got %h expected %h (lat %0d)", i, res, ex[i], lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          nxt   = 1;
        int          n_got = 0;
        logic        hold;
        logic        acc;
        logic [15:0] h_sum;
        logic [3:0]  h_tag;
        int          exp_tag;
        h_sum = '0; h_tag = '0;
        for (int cyc = 0; cyc < 40 && n_got < 6; cyc++) begin
            @(negedge clk);
            hold      = (cyc >= 3 && cyc <= 5);
            out_ready = !hold;
            if (nxt <= 6) begin
                in_valid = 1'b1; in_op = OP_ADD; in_cin = 1'b0;
                in_a = 16'(nxt * 16'h0111); in_b = 16'(nxt); in_tag = 4'(nxt);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (hold) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_err++; $display("FAIL b2b_hold_in_ready cyc%0d: got %b expected 0", cyc, in_ready);
                end
                if (cyc == 3) begin
                    h_sum = out_sum; h_tag = out_tag;
                    n_cmp++;
                    if (out_valid !== 1'b1) begin
                        n_err++; $display("FAIL b2b_hold_valid: got %b expected 1", out_valid);
                    end
                end else begin
                    n_cmp++;
                    if ({out_valid, out_tag, out_sum} !== {1'b1, h_tag, h_sum}) begin
                        n_err++;
                        $display("FAIL b2b_hold_stable cyc%0d: got %h expected %h", cyc,
                                 {out_valid, out_tag, out_sum}, {1'b1, h_tag, h_sum});
                    end
                end
            end
            if (out_valid && out_ready) begin
                exp_tag = n_got + 1;
                n_cmp++;
                if ({out_tag, out_sum} !== {4'(exp_tag), 16'(exp_tag * 16'h0112)}) begin
                    n_err++;
                    $display("FAIL b2b_out%0d: got %h expected %h", n_got,
                             {out_tag, out_sum}, {4'(exp_tag), 16'(exp_tag * 16'h0112)});
                end
                n_got++;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) nxt++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++;
        if (n_got != 6) begin
            n_err++; $display("FAIL b2b_count: got %0d expected 6", n_got);
        end
    endtask

    task automatic test_flush();
        logic leak;
        @(negedge clk);
        out_ready = 1'b1; in_op = OP_ADD; in_cin = 1'b0;
        in_valid = 1'b1; in_a = 16'h0001; in_b = 16'h0001; in_tag = 4'd1;
        @(negedge clk);
        in_a = 16'h0002; in_b = 16'h0002; in_tag = 4'd2;
        @(negedge clk);
        in_a = 16'h0003; in_b = 16'h0003; in_tag = 4'd3;
        flush = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL flush_in_ready: got %b expected 0", in_ready);
        end
        n_cmp++;
        if ({out_valid, out_tag, out_sum} !== {1'b1, 4'd1, 16'h0002}) begin
            n_err++; $display("FAIL flush_pre_out: got %h expected %h", {out_valid, out_tag, out_sum}, {1'b1, 4'd1, 16'h0002});
        end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_next_valid: got %b expected 0", out_valid);
        end
        leak = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid !== 1'b0) leak = 1'b1;
        end
        n_cmp++;
        if (leak !== 1'b0) begin
            n_err++; $display("FAIL flush_leak: got %b expected 0", leak);
        end
    endtask

    task automatic test_async_reset();
        logic leak;
        @(negedge clk);
        out_ready = 1'b0; in_op = OP_ADD; in_cin = 1'b0;
        in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h4321; in_tag = 4'd5;
        @(negedge clk);
        in_a = 16'h0F0F; in_b = 16'h0101; in_tag = 4'd6;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_tag, out_sum} !== {1'b1, 4'd5, 16'h5555}) begin
            n_err++; $display("FAIL arst_pre_out: got %h expected %h", {out_valid, out_tag, out_sum}, {1'b1, 4'd5, 16'h5555});
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, out_tag, out_zero, out_ovf, out_cout, out_sum} !== 24'd0) begin
            n_err++;
            $display("FAIL arst_outputs: got %h expected 0", {out_valid, out_tag, out_zero, out_ovf, out_cout, out_sum});
        end
        rst = 1'b0;
        out_ready = 1'b1;
        leak = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid !== 1'b0) leak = 1'b1;
        end
        n_cmp++;
        if (leak !== 1'b0) begin
            n_err++; $display("FAIL arst_leak: got %b expected 0", leak);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL arst_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_random();
        logic [22:0] q[$];
        logic [22:0] exp;
        logic [22:0] got;
        int          issued = 0;
        int          n_rx   = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (issued < 40) begin
                in_valid = 1'b1;
                in_a   = (cyc % 7 == 0) ? 16'hFFFF : 16'($urandom);
                in_b   = (cyc % 5 == 0) ? 16'h8000 : 16'($urandom);
                in_cin = 1'($urandom);
                in_op  = 1'($urandom);
                in_tag = 4'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                got = {out_tag, out_zero, out_ovf, out_cout, out_sum};
                exp = (q.size() != 0) ? q.pop_front() : 23'h7FFFFF;
                n_cmp++;
                if (got !== exp) begin
                    n_err++; $display("FAIL rand%0d: got %h expected %h", n_rx, got, exp);
                end
                n_rx++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in_a, in_b, in_cin, in_op, in_tag));
                issued++;
            end
            @(posedge clk);
        end
        n_cmp++;
        if (n_rx != 40) begin
            n_err++; $display("FAIL rand_count: got %0d expected 40", n_rx);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
